// File: rtl/nss_pkg.sv
// Shared definitions for the nibble-serial subtractor: nibble width, FSM states
// and the nibble-counter width helper.
package nss_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-nibble datapath still needs a 1-bit counter.
  function automatic int cnt_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice; the subtractor feeds it x + ~y + ~borrow.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = x ^ y;
  assign g = x & y;

  // Every carry is expanded from ci directly rather than rippled.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per clock, LSB nibble first,
// with a start/busy/done handshake and fully registered outputs.
module nibble_serial_subtractor
  import nss_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int CW  = cnt_width(NIB);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
    $error("nibble_serial_subtractor: WIDTH must be a positive multiple of 4");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       cla_sum;
  logic             cla_co;
  logic [WIDTH-1:0] res_shift;

  cla4_slice u_cla (
    .x  (a_sh_q[3:0]),
    .y  (~b_sh_q[3:0]),
    .ci (~borrow_q),
    .s  (cla_sum),
    .co (cla_co)
  );

  // New nibble enters at the top so after NIB steps the LSB nibble sits at bit 0.
  assign res_shift = WIDTH'({cla_sum, res_q} >> NIB_W);

  // State, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      CALC: begin
        a_sh_d   = a_sh_q >> NIB_W;
        b_sh_d   = b_sh_q >> NIB_W;
        res_d    = res_shift;
        borrow_d = ~cla_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = res_shift;
          bout_d  = ~cla_co;
          ovf_d   = (a_msb_q ^ b_msb_q) & (res_shift[WIDTH-1] ^ a_msb_q);
        end else begin
          busy_d = 1'b1;
        end
      end
      IDLE, DONE: begin
        if (start) begin
          state_d  = CALC;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = {CW{1'b0}};
          res_d    = {WIDTH{1'b0}};
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        bin = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] prev_diff = 16'h0000;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                                output logic [15:0] d, output logic bo, output logic ov);
    int r_u;
    int r_s;
    r_u = int'(ma) - int'(mb) - int'(mbin);
    r_s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    d   = r_u[15:0];
    bo  = (r_u < 0);
    ov  = (r_s > 32767) || (r_s < -32768);
  endfunction

  // Present an operation; returns at the negedge just after the accepting edge.
  task automatic launch(input logic [15:0] la, input logic [15:0] lb, input logic lbin);
    a = la; b = lb; bin = lbin; start = 1'b1;
    @(negedge clk);
  endtask

  // Entered at the negedge after the accepting edge; optionally chains the next op in DONE.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                        input bit noise, input bit chain,
                        input logic [15:0] na, input logic [15:0] nb, input logic nbin);
    logic [15:0] ed;
    logic        eb;
    logic        eo;
    int          lat;
    bit          got;
    model(ta, tb_, tbin, ed, eb, eo);
    check("accept_busy", busy, 1);
    check("accept_done", done, 0);
    got = 0;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      if (!got) begin
        start = noise;
        a = 16'($urandom);
        b = 16'($urandom);
        bin = 1'($urandom);
        @(negedge clk);
        if (done === 1'b1) begin
          got = 1;
          lat = n;
        end else begin
          check("busy_hold", busy, 1);
          check("diff_stable", diff, prev_diff);
        end
      end
    end
    if (!got) check("done_timeout", 0, 1);
    check("latency", lat, 4);
    check("diff", diff, ed);
    check("bout", bout, eb);
    check("ovf", ovf, eo);
    check("busy_at_done", busy, 0);
    prev_diff = ed;
    if (chain) begin
      a = na; b = nb; bin = nbin; start = 1'b1;
    end else begin
      start = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, chain);
    check("diff_held", diff, ed);
  endtask

  initial begin
    logic [15:0] ca, cb, xa, xb;
    logic        cbin, xbin;
    bit          ch;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    launch(16'h1234, 16'h0234, 1'b0); run_op(16'h1234, 16'h0234, 1'b0, 0, 0, 16'h0, 16'h0, 1'b0);
    launch(16'h0000, 16'h0001, 1'b0); run_op(16'h0000, 16'h0001, 1'b0, 0, 0, 16'h0, 16'h0, 1'b0);
    launch(16'h1000, 16'h0001, 1'b0); run_op(16'h1000, 16'h0001, 1'b0, 0, 0, 16'h0, 16'h0, 1'b0);
    launch(16'h8000, 16'h0001, 1'b0); run_op(16'h8000, 16'h0001, 1'b0, 0, 0, 16'h0, 16'h0, 1'b0);
    launch(16'h7FFF, 16'hFFFF, 1'b0); run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 0, 16'h0, 16'h0, 1'b0);
    launch(16'h0005, 16'h0003, 1'b1); run_op(16'h0005, 16'h0003, 1'b1, 1, 0, 16'h0, 16'h0, 1'b0);

    // Back-to-back: second op accepted in the DONE cycle.
    launch(16'hA5A5, 16'h5A5A, 1'b0);
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 0, 1, 16'h0001, 16'h0002, 1'b1);
    run_op(16'h0001, 16'h0002, 1'b1, 0, 0, 16'h0, 16'h0, 1'b0);

    // Reset on the second CALC edge discards the operation.
    launch(16'h4321, 16'h1111, 1'b1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_bout", bout, 0);
    check("midrst_ovf", ovf, 0);
    prev_diff = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after_rst", done, 0);
      check("idle_after_rst", busy, 0);
    end
    launch(16'h0F0F, 16'h00FF, 1'b1); run_op(16'h0F0F, 16'h00FF, 1'b1, 0, 0, 16'h0, 16'h0, 1'b0);

    // Randomized operations with occasional ignored starts and chaining.
    xa = 16'($urandom); xb = 16'($urandom); xbin = 1'($urandom);
    launch(xa, xb, xbin);
    for (int i = 0; i < 24; i++) begin
      ca = xa; cb = xb; cbin = xbin;
      xa = 16'($urandom); xb = 16'($urandom); xbin = 1'($urandom);
      ch = (i < 23) && ($urandom_range(2) == 0);
      run_op(ca, cb, cbin, bit'($urandom_range(1)), ch, xa, xb, xbin);
      if (!ch && i < 23) launch(xa, xb, xbin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
